// File: rtl/adel_pipe_if.sv
// rtl/adel_pipe_if.sv - instruction-memory, status and debug bundle for adel_pipe
// The core drives the master side; the harness and instruction memory use the slave side.
interface adel_pipe_if #(
    parameter int DW   = 16,
    parameter int NREG = 4,
    parameter int IMMW = 8,
    parameter int PCW  = 16
) ();
    localparam int RA = $clog2(NREG);
    localparam int IW = 4 + 2 * RA + IMMW;

    logic [PCW-1:0] pc;
    logic [IW-1:0]  inst;
    logic           inst_valid;
    logic           halted;
    logic [RA-1:0]  dbg_raddr;
    logic [DW-1:0]  dbg_rdata;
`ifdef ADEL_PIPE_TRACE_EN
    logic           retire_valid;
    logic [PCW-1:0] retire_pc;
    logic           retire_wen;
    logic [DW-1:0]  retire_wdata;
`endif

    modport master (
        output pc, halted, dbg_rdata,
`ifdef ADEL_PIPE_TRACE_EN
        output retire_valid, retire_pc, retire_wen, retire_wdata,
`endif
        input  inst, inst_valid, dbg_raddr
    );

    modport slave (
        input  pc, halted, dbg_rdata,
`ifdef ADEL_PIPE_TRACE_EN
        input  retire_valid, retire_pc, retire_wen, retire_wdata,
`endif
        output inst, inst_valid, dbg_raddr
    );
endinterface

// File: rtl/adel_pipe.sv
// rtl/adel_pipe.sv - two-stage fetch/execute accumulator core with branch flush and self-branch halt
// Optional retire trace outputs are enabled by defining ADEL_PIPE_TRACE_EN.
module adel_pipe #(
    parameter int DW   = 16,
    parameter int NREG = 4,
    parameter int IMMW = 8,
    parameter int PCW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    adel_pipe_if.master   bus
);
    localparam int RA = $clog2(NREG);
    localparam int IW = 4 + 2 * RA + IMMW;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [IW-1:0]  ir_q, ir_d;
    logic [PCW-1:0] ir_pc_q, ir_pc_d;
    logic [DW-1:0]  rf_q [NREG];
    logic [DW-1:0]  rf_d [NREG];

    logic           ir_w;
    logic [1:0]     ir_opc;
    logic           ir_rs;
    logic [RA-1:0]  ir_dest;
    logic [RA-1:0]  ir_src1;
    logic [IMMW-1:0] ir_imm;
    logic [DW-1:0]  op1, op2, alu_res;
    logic [PCW-1:0] br_target;
    logic           br_cond, br_taken;

    assign ir_w    = ir_q[IW-1];
    assign ir_opc  = ir_q[IW-2 -: 2];
    assign ir_rs   = ir_q[IW-4];
    assign ir_dest = ir_q[IW-5 -: RA];
    assign ir_src1 = ir_q[IW-5-RA -: RA];
    assign ir_imm  = ir_q[IMMW-1:0];

    assign op1       = rf_q[ir_src1];
    assign op2       = ir_rs ? rf_q[ir_imm[RA-1:0]] : DW'(ir_imm);
    assign br_target = ir_pc_q + {{(PCW-IMMW){ir_imm[IMMW-1]}}, ir_imm};

    always_comb begin
        alu_res = '0;
        br_cond = 1'b0;
        case (ir_opc)
            2'b00: begin alu_res = op1 + op2; br_cond = (op1 == '0);                    end
            2'b01: begin alu_res = op1 - op2; br_cond = (op1 != '0);                    end
            2'b10: begin alu_res = op1 & op2; br_cond = op1[DW-1];                      end
            default: begin alu_res = op1 | op2; br_cond = !op1[DW-1] && (op1 != '0);  end
        endcase
    end

    assign br_taken = (state_q == S_RUN) && !ir_w && br_cond;

    // Execute and fetch share one cycle; a taken branch overrides the fetch so the
    // instruction presented in that cycle is dropped (the one-bubble penalty).
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ir_pc_d  = ir_pc_q;
        rf_d     = rf_q;
        if (state_q != S_HALT) begin
            if ((state_q == S_RUN) && ir_w) begin
                rf_d[ir_dest] = alu_res;
            end
            if (br_taken && (ir_imm == '0)) begin
                state_d = S_HALT;
                pc_d    = ir_pc_q;
            end else if (br_taken) begin
                state_d = S_EMPTY;
                pc_d    = br_target;
            end else if (bus.inst_valid) begin
                state_d = S_RUN;
                ir_d    = bus.inst;
                ir_pc_d = pc_q;
                pc_d    = pc_q + 1'b1;
            end else begin
                state_d = S_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            ir_q    <= '0;
            ir_pc_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.halted    = (state_q == S_HALT);
    assign bus.dbg_rdata = rf_q[bus.dbg_raddr];

`ifdef ADEL_PIPE_TRACE_EN
    logic           retire_valid_q;
    logic [PCW-1:0] retire_pc_q;
    logic           retire_wen_q;
    logic [DW-1:0]  retire_wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_valid_q <= 1'b0;
            retire_pc_q    <= '0;
            retire_wen_q   <= 1'b0;
            retire_wdata_q <= '0;
        end else begin
            retire_valid_q <= (state_q == S_RUN);
            retire_pc_q    <= ir_pc_q;
            retire_wen_q   <= (state_q == S_RUN) && ir_w;
            retire_wdata_q <= ((state_q == S_RUN) && ir_w) ? alu_res : '0;
        end
    end

    assign bus.retire_valid = retire_valid_q;
    assign bus.retire_pc    = retire_pc_q;
    assign bus.retire_wen   = retire_wen_q;
    assign bus.retire_wdata = retire_wdata_q;
`endif
endmodule

// File: doc/adel_pipe.md
Name: adel_pipe

Overview:
- Parametrised two-stage (fetch / execute) successor of the team's 4-register accumulator-style core.
- Generalised data width, register count, immediate width and PC width.
- Adds an instruction-valid handshake, a branch flush with a one-bubble penalty, a halt-on-self-branch state, and a debug register read port.
- Sits between a combinational instruction memory (addressed by pc) and the test harness.

Parameters:
- DW, 16, datapath and register width.
- NREG, 4, register count; power of 2, minimum 2; RA = clog2(NREG).
- IMMW, 8, immediate width; must be >= RA.
- PCW, 16, program counter width.
- IW, derived as 4+2*RA+IMMW (16 at defaults); instruction width, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- pc  out  PCW  fetch address to instruction memory.
- inst  in  IW  instruction at pc, same cycle.
- inst_valid  in  1  inst is valid this cycle.
- halted  out  1  core stopped on a self-branch.
- dbg_raddr  in  RA  debug register select.
- dbg_rdata  out  DW  combinational rf[dbg_raddr].

Behaviour:
- Encoding, MSB to LSB: w(1), opc(2), rs(1), dest(RA), src1(RA), imm(IMMW). src2 = imm[RA-1:0].
- Reset (async, rst=1): pc=0, IR invalid, ir_pc=0, all rf=0, halted=0. Effect is immediate and clock-independent, including mid-operation. Any in-flight IR is discarded.
- Fetch, when not halted and no flush this cycle:
  - inst_valid=1: IR<=inst, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
  - inst_valid=0: ir_valid<=0, pc holds.
- Execute, when ir_valid=1 and not halted:
  - w=1 (ALU): op2 = rs ? rf[src2] : zero-extended imm. Result rf[dest] = rf[src1] op op2, with opc 00 add, 01 sub, 10 and, 11 or.
  - ALU results are modulo 2^DW; no flags.
  - Writes land at the clock edge ending execute. The next instruction reads the new value, so there are no hazards and no forwarding.
  - w=0 (branch): condition on rf[src1] as signed: opc 00 ==0, 01 !=0, 10 <0, 11 >0.
  - Branch target = ir_pc + sign-extended imm, modulo 2^PCW.
  - Branch taken: pc<=target and ir_valid<=0. The instruction fetched in the same cycle is discarded (one-bubble penalty).
  - Branch not taken: no effect; fetch proceeds normally.
- Halt: a taken branch with imm==0 sets halted=1, pc<=ir_pc, ir_valid<=0.
  - While halted: no fetch, no execute, rf frozen, inst/inst_valid ignored.
  - Only rst clears halted.
- States: EMPTY (ir_valid=0), RUN (ir_valid=1), HALT. Transitions:
  - EMPTY to RUN on inst_valid.
  - RUN to EMPTY on taken branch or inst_valid=0.
  - RUN to HALT on self-branch.
  - Any state to EMPTY on rst.
- dbg_rdata shows pre-write register contents during the cycle a write to the same register is pending.
- pc wraps from 2^PCW-1 to 0 silently.

Optional Feature:
- Macro: ADEL_PIPE_TRACE_EN.
- Defined: adds outputs retire_valid (1), retire_pc (PCW), retire_wen (1), retire_wdata (DW), all registered.
  - retire_valid pulses one cycle after each executed (not flushed) instruction.
  - retire_wen=1 for ALU ops; retire_wdata is the value written.
  - Trace outputs reset to 0.
- Undefined: ports absent; core behaviour identical.

Test Plan (defaults; "edge n" = nth rising clock edge after reset release):
- Reset, inst_valid=1, inst=0x8405 (r1=r0+5) at pc=0 -> captured edge 1; dbg_raddr=1 reads 5 after edge 2; pc=2 after edge 2.
- r1=5, then inst=0xB901 (r2=r1-r1, rs=1) -> dbg r2=0. Then r3 = r3 - 1 on r3=0 -> dbg r3=0xFFFF (wrap).
- BNE r1,-2 (0x21FE) at ir_pc=4 with r1=5 -> pc=2 next edge. The instruction at pc=5 (r3=r0+7) is not executed: r3 unchanged, 1 bubble.
- inst_valid=0 for 3 cycles mid-stream -> pc holds, no rf writes, ir_valid low. Resumes at the same pc when valid returns.
- BEQ r2,0 (0x0200) with r2=0 at ir_pc=6 -> halted=1, pc=6 held; later inst values ignored and rf unchanged over 10 cycles; rst -> halted=0, pc=0.
- rst pulsed between edges while RUN with a pending write -> pc=0, all rf=0, halted=0 before the next edge; no write lands.
